// File: rtl/acl_iface_pio_pkg.sv
// Shared constants for the ACL interface PIO family: Avalon register map and edge-capture modes.
package acl_iface_pio_pkg;

   localparam logic [2:0] ADDR_DATA         = 3'd0;
   localparam logic [2:0] ADDR_INPUT        = 3'd1;
   localparam logic [2:0] ADDR_IRQ_MASK     = 3'd2;
   localparam logic [2:0] ADDR_EDGE_CAP     = 3'd3;
   localparam logic [2:0] ADDR_OUTSET       = 3'd4;
   localparam logic [2:0] ADDR_OUTCLR       = 3'd5;
   localparam logic [2:0] ADDR_BLINK_EN     = 3'd6;
   localparam logic [2:0] ADDR_BLINK_PERIOD = 3'd7;

   localparam int EDGE_RISING  = 0;
   localparam int EDGE_FALLING = 1;
   localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/acl_iface_pio_blink.sv
// Free-running blink timebase: a down-counter that reloads from period and flips phase on expiry.
module acl_iface_pio_blink #(
   parameter int                     BLINK_CNT_W      = 24,
   parameter logic [BLINK_CNT_W-1:0] BLINK_PERIOD_RST = 24'd12_500_000
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [BLINK_CNT_W-1:0] period,
   output logic                   phase
);

   logic [BLINK_CNT_W-1:0] r_cnt;
   logic                   r_phase;

   // NOTE: non-blocking assignments so every flop samples its pre-edge inputs.
   // A new period is only picked up at the next expiry; the running count is never reloaded early.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt   <= BLINK_PERIOD_RST;
         r_phase <= 1'b1;
      end else if (r_cnt == '0) begin
         r_cnt   <= period;
         r_phase <= ~r_phase;
      end else begin
         r_cnt   <= r_cnt - BLINK_CNT_W'(1);
      end
   end

   assign phase = r_phase;

endmodule

// File: rtl/acl_iface_gpio_pio.sv
// Avalon-MM GPIO PIO: set/clear output register with per-bit blink, synchronised inputs with
// edge capture and a maskable level interrupt.
module acl_iface_gpio_pio
   import acl_iface_pio_pkg::*;
#(
   parameter int                     WIDTH            = 7,
   parameter logic [WIDTH-1:0]       RESET_VALUE      = 7'h7F,
   parameter int                     EDGE_TYPE        = 0,
   parameter int                     BLINK_CNT_W      = 24,
   parameter logic [BLINK_CNT_W-1:0] BLINK_PERIOD_RST = 24'd12_500_000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   logic [WIDTH-1:0]       r_data_out;
   logic [WIDTH-1:0]       r_irq_mask;
   logic [WIDTH-1:0]       r_blink_en;
   logic [BLINK_CNT_W-1:0] r_period;
   logic [WIDTH-1:0]       r_capture;
   logic [WIDTH-1:0]       r_sync1;
   logic [WIDTH-1:0]       r_in_sync;
   logic [WIDTH-1:0]       r_in_prev;
   logic                   r_irq;

   logic                   w_wr;
   logic [WIDTH-1:0]       w_wd;
   logic [WIDTH-1:0]       w_edge;
   logic [WIDTH-1:0]       w_clr;
   logic                   w_phase;
   logic                   w_unused_wd;

   assign w_wr        = chipselect & ~write_n;
   assign w_wd        = writedata[WIDTH-1:0];
   assign w_unused_wd = &{1'b0, writedata};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_data_out <= RESET_VALUE;
         r_irq_mask <= '0;
         r_blink_en <= '0;
         r_period   <= BLINK_PERIOD_RST;
      end else if (w_wr) begin
         case (address)
            ADDR_DATA:         r_data_out <= w_wd;
            ADDR_OUTSET:       r_data_out <= r_data_out | w_wd;
            ADDR_OUTCLR:       r_data_out <= r_data_out & ~w_wd;
            ADDR_IRQ_MASK:     r_irq_mask <= w_wd;
            ADDR_BLINK_EN:     r_blink_en <= w_wd;
            ADDR_BLINK_PERIOD: r_period   <= writedata[BLINK_CNT_W-1:0];
            default:           ;
         endcase
      end
   end

   // Two flops for metastability, a third holds the previous synchronised sample.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1   <= '0;
         r_in_sync <= '0;
         r_in_prev <= '0;
      end else begin
         r_sync1   <= in_port;
         r_in_sync <= r_sync1;
         r_in_prev <= r_in_sync;
      end
   end

   always_comb begin
      case (EDGE_TYPE)
         EDGE_FALLING: w_edge = ~r_in_sync & r_in_prev;
         EDGE_ANY:     w_edge = r_in_sync ^ r_in_prev;
         default:      w_edge = r_in_sync & ~r_in_prev;
      endcase
   end

   assign w_clr = (w_wr && address == ADDR_EDGE_CAP) ? w_wd : '0;

   // A fresh edge is OR-ed in after the clear, so it survives a same-cycle W1C.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_capture <= '0;
         r_irq     <= 1'b0;
      end else begin
         r_capture <= (r_capture & ~w_clr) | w_edge;
         r_irq     <= |(r_capture & r_irq_mask);
      end
   end

   acl_iface_pio_blink #(
      .BLINK_CNT_W      (BLINK_CNT_W),
      .BLINK_PERIOD_RST (BLINK_PERIOD_RST)
   ) u_blink (
      .clk     (clk),
      .reset_n (reset_n),
      .period  (r_period),
      .phase   (w_phase)
   );

   // NOTE: readdata gets a default before the case so the read mux cannot infer a latch.
   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA:         readdata[WIDTH-1:0]       = r_data_out;
         ADDR_INPUT:        readdata[WIDTH-1:0]       = r_in_sync;
         ADDR_IRQ_MASK:     readdata[WIDTH-1:0]       = r_irq_mask;
         ADDR_EDGE_CAP:     readdata[WIDTH-1:0]       = r_capture;
         ADDR_BLINK_EN:     readdata[WIDTH-1:0]       = r_blink_en;
         ADDR_BLINK_PERIOD: readdata[BLINK_CNT_W-1:0] = r_period;
         default:           readdata                  = '0;
      endcase
   end

   assign out_port = r_data_out & ~(r_blink_en & {WIDTH{~w_phase}});
   assign irq      = r_irq;

endmodule

// File: tb/tb_acl_iface_gpio_pio.sv
// Directed bench for acl_iface_gpio_pio: register-map vector table plus blink, edge-capture and reset sequences.
module tb_acl_iface_gpio_pio;

   logic        clk;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [6:0]  out_port;
   logic [6:0]  in_port;
   logic        irq;

   int n_cmp = 0;
   int n_err = 0;

   acl_iface_gpio_pio #(
      .WIDTH            (7),
      .RESET_VALUE      (7'h7F),
      .EDGE_TYPE        (0),
      .BLINK_CNT_W      (24),
      .BLINK_PERIOD_RST (24'd10)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port),
      .in_port    (in_port),
      .irq        (irq)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        wr;
      logic [2:0]  addr;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic [6:0]  exp_out;
   } vec_t;

   localparam int NVEC = 19;
   vec_t vecs [NVEC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Called at a negedge; the write lands on the next posedge and the task returns at the following negedge.
   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      #1;
      d          = readdata;
      chipselect = 1'b0;
   endtask

   logic [31:0] rd;
   logic [6:0]  s [24];
   logic [6:0]  p [9];
   int          i0;
   logic        expbit;

   initial begin
      vecs[0]  = '{1'b0, 3'd0, 32'h0,         32'h7F,     7'h7F};
      vecs[1]  = '{1'b1, 3'd0, 32'h15,        32'h0,      7'h15};
      vecs[2]  = '{1'b0, 3'd0, 32'h0,         32'h15,     7'h15};
      vecs[3]  = '{1'b1, 3'd4, 32'h60,        32'h0,      7'h75};
      vecs[4]  = '{1'b1, 3'd5, 32'h05,        32'h0,      7'h70};
      vecs[5]  = '{1'b0, 3'd4, 32'h0,         32'h0,      7'h70};
      vecs[6]  = '{1'b0, 3'd5, 32'h0,         32'h0,      7'h70};
      vecs[7]  = '{1'b0, 3'd0, 32'h0,         32'h70,     7'h70};
      vecs[8]  = '{1'b1, 3'd1, 32'hFF,        32'h0,      7'h70};
      vecs[9]  = '{1'b0, 3'd1, 32'h0,         32'h0,      7'h70};
      vecs[10] = '{1'b1, 3'd2, 32'hFFFF_FF82, 32'h0,      7'h70};
      vecs[11] = '{1'b0, 3'd2, 32'h0,         32'h02,     7'h70};
      vecs[12] = '{1'b0, 3'd3, 32'h0,         32'h0,      7'h70};
      vecs[13] = '{1'b0, 3'd7, 32'h0,         32'd10,     7'h70};
      vecs[14] = '{1'b1, 3'd7, 32'hFF00_0003, 32'h0,      7'h70};
      vecs[15] = '{1'b0, 3'd7, 32'h0,         32'h3,      7'h70};
      vecs[16] = '{1'b1, 3'd0, 32'hFFFF_FFFF, 32'h0,      7'h7F};
      vecs[17] = '{1'b0, 3'd0, 32'h0,         32'h7F,     7'h7F};
      vecs[18] = '{1'b0, 3'd6, 32'h0,         32'h0,      7'h7F};

      reset_n    = 1'b1;
      address    = '0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      in_port    = '0;

      // Reset asserted asynchronously, between clock edges.
      #2 reset_n = 1'b0;
      #1;
      check("reset_out_port", {25'd0, out_port}, 32'h7F);
      check("reset_irq", {31'd0, irq}, 32'h0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("post_reset_out_port", {25'd0, out_port}, 32'h7F);

      // Register map table.
      for (int k = 0; k < NVEC; k++) begin
         if (vecs[k].wr) begin
            bus_write(vecs[k].addr, vecs[k].wd);
         end else begin
            bus_read(vecs[k].addr, rd);
            check($sformatf("vec%0d_readdata", k), rd, vecs[k].exp_rd);
         end
         check($sformatf("vec%0d_out_port", k), {25'd0, out_port}, {25'd0, vecs[k].exp_out});
      end
      check("irq_idle", {31'd0, irq}, 32'h0);

      // Blink with period 3: phase holds 4 clocks, bit 0 has an 8-clock period, bits 6:1 untouched.
      bus_write(3'd6, 32'h01);
      repeat (20) @(negedge clk);
      for (int k = 0; k < 24; k++) begin
         s[k] = out_port;
         @(negedge clk);
      end
      i0 = 1;
      for (int k = 5; k >= 1; k--) if (s[k][0] != s[k-1][0]) i0 = k;
      for (int k = 1; k < 16; k++) begin
         expbit = s[i0][0] ^ 1'((k / 4) % 2);
         check($sformatf("blink_p3_s%0d", k), {25'd0, s[i0+k]}, {25'd0, 6'h3F, expbit});
      end

      // Period 0 toggles every cycle once the current count expires.
      bus_write(3'd7, 32'h0);
      repeat (6) @(negedge clk);
      for (int k = 0; k < 9; k++) begin
         p[k] = out_port;
         @(negedge clk);
      end
      for (int k = 1; k < 9; k++)
         check($sformatf("blink_p0_s%0d", k), {25'd0, p[k]}, {25'd0, 6'h3F, ~p[k-1][0]});
      bus_write(3'd6, 32'h0);
      check("blink_off_out_port", {25'd0, out_port}, 32'h7F);

      // Rising edge on in_port[1]: capture after 3 edges, irq one edge later.
      in_port[1] = 1'b1;
      repeat (2) @(negedge clk);
      bus_read(3'd3, rd);
      check("edge_cap_after_2", rd, 32'h0);
      @(negedge clk);
      bus_read(3'd3, rd);
      check("edge_cap_after_3", rd, 32'h02);
      check("irq_after_3", {31'd0, irq}, 32'h0);
      @(negedge clk);
      check("irq_after_4", {31'd0, irq}, 32'h1);
      bus_write(3'd3, 32'h02);
      bus_read(3'd3, rd);
      check("edge_cap_w1c", rd, 32'h0);
      check("irq_w1c_same", {31'd0, irq}, 32'h1);
      @(negedge clk);
      check("irq_w1c_next", {31'd0, irq}, 32'h0);
      in_port[1] = 1'b0;
      repeat (5) @(negedge clk);
      bus_read(3'd3, rd);
      check("edge_cap_falling", rd, 32'h0);
      check("irq_falling", {31'd0, irq}, 32'h0);

      // W1C landing on the same edge as a new capture: the edge wins.
      in_port[1] = 1'b1;
      repeat (4) @(negedge clk);
      check("irq_before_race", {31'd0, irq}, 32'h1);
      in_port[1] = 1'b0;
      repeat (4) @(negedge clk);
      in_port[1] = 1'b1;
      repeat (2) @(negedge clk);
      bus_write(3'd3, 32'h02);
      bus_read(3'd3, rd);
      check("race_edge_cap", rd, 32'h02);
      check("race_irq", {31'd0, irq}, 32'h1);
      @(negedge clk);
      check("race_irq_next", {31'd0, irq}, 32'h1);

      // Reset mid-blink with capture pending.
      bus_write(3'd7, 32'h3);
      bus_write(3'd6, 32'h7F);
      repeat (3) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("midrst_out_port", {25'd0, out_port}, 32'h7F);
      check("midrst_irq", {31'd0, irq}, 32'h0);
      bus_read(3'd3, rd);
      check("midrst_edge_cap", rd, 32'h0);
      @(negedge clk);
      in_port = '0;
      @(negedge clk);
      reset_n = 1'b1;
      // Counter restarts from 10: phase flips on the 11th and 22nd edges after release.
      bus_write(3'd6, 32'h01);
      repeat (9) @(negedge clk);
      check("restart_edge10", {25'd0, out_port}, 32'h7F);
      @(negedge clk);
      check("restart_edge11", {25'd0, out_port}, 32'h7E);
      repeat (10) @(negedge clk);
      check("restart_edge21", {25'd0, out_port}, 32'h7E);
      @(negedge clk);
      check("restart_edge22", {25'd0, out_port}, 32'h7F);
      bus_read(3'd3, rd);
      check("restart_edge_cap", rd, 32'h0);
      bus_read(3'd7, rd);
      check("restart_period", rd, 32'd10);
      check("restart_irq", {31'd0, irq}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
